// File: rtl/speicher_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : speicher_arbiter_if
// Brief    : CPU fetch/load/store channels and single-port memory bus of the
//            memory arbiter, bundled for the arbiter port list.
// Revision : 1.0 - initial release
// ============================================================================
interface speicher_arbiter_if;
  logic [31:0] InstruktionAdresse;
  logic        LeseInstruktion;
  logic [31:0] Instruktion;
  logic        InstruktionGeladen;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenRaus;
  logic        LeseDaten;
  logic        SchreibeDaten;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [31:0] SpeicherAdresse;
  logic [31:0] SpeicherSchreibDaten;
  logic        SpeicherLesen;
  logic        SpeicherSchreiben;
  logic [31:0] SpeicherLeseDaten;
  logic        SpeicherBereit;
  logic        Fehler;

  // Arbiter view: it serves the CPU requests and masters the memory bus.
  modport master (
    input  InstruktionAdresse, LeseInstruktion, DatenAdresse, DatenRaus,
           LeseDaten, SchreibeDaten, SpeicherLeseDaten, SpeicherBereit,
    output Instruktion, InstruktionGeladen, DatenRein, DatenGeladen,
           DatenGespeichert, SpeicherAdresse, SpeicherSchreibDaten,
           SpeicherLesen, SpeicherSchreiben, Fehler
  );

  modport slave (
    output InstruktionAdresse, LeseInstruktion, DatenAdresse, DatenRaus,
           LeseDaten, SchreibeDaten, SpeicherLeseDaten, SpeicherBereit,
    input  Instruktion, InstruktionGeladen, DatenRein, DatenGeladen,
           DatenGespeichert, SpeicherAdresse, SpeicherSchreibDaten,
           SpeicherLesen, SpeicherSchreiben, Fehler
  );
endinterface
`default_nettype wire

// File: rtl/speicher_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : speicher_arbiter
// Brief    : Arbitrates CPU store/load/fetch requests onto one memory port,
//            priority store > load > fetch, with latched address/data.
// Options  : `define TIMEOUT_EN adds a wait-cycle limit and sticky Fehler flag.
// Revision : 1.0 - initial release
// ============================================================================
module speicher_arbiter #(
  parameter int unsigned TIMEOUT_ZYKLEN = 255,
  parameter logic [31:0] FEHLER_WORT    = 32'hFFFF_FFFF
) (
  input  wire logic           Clock,
  input  wire logic           Reset,
  speicher_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    LEER      = 3'd0,
    INSTR     = 3'd1,
    LESEN     = 3'd2,
    SCHREIBEN = 3'd3,
    FERTIG    = 3'd4
  } zustand_t;

  zustand_t    r_zustand;
  zustand_t    w_naechster;
  logic [31:0] r_adresse;
  logic [31:0] r_schreibDaten;
  logic [31:0] r_instruktion;
  logic [31:0] r_datenRein;
  logic        r_lesen;
  logic        r_schreiben;
  logic        r_instrGeladen;
  logic        r_datenGeladen;
  logic        r_datenGespeichert;
  logic        w_zugriff;
  logic        w_timeout;
  logic        w_beendet;

  assign w_zugriff = (r_zustand == INSTR) || (r_zustand == LESEN) ||
                     (r_zustand == SCHREIBEN);
  assign w_beendet = w_zugriff && (bus.SpeicherBereit || w_timeout);

`ifdef TIMEOUT_EN
  localparam int c_ZAEHLER_BREITE =
    ($clog2(TIMEOUT_ZYKLEN + 1) > 8) ? $clog2(TIMEOUT_ZYKLEN + 1) : 8;

  logic [c_ZAEHLER_BREITE-1:0] r_zaehler;
  logic                        r_fehler;

  // Counter holds the number of already-elapsed unacknowledged cycles, so the
  // limit is hit in the TIMEOUT_ZYKLEN-th cycle that still lacks SpeicherBereit.
  assign w_timeout = w_zugriff && !bus.SpeicherBereit &&
                     (r_zaehler == c_ZAEHLER_BREITE'(TIMEOUT_ZYKLEN - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_zaehler <= '0;
      r_fehler  <= 1'b0;
    end else begin
      if (r_zustand == LEER) begin
        r_zaehler <= '0;
      end else if (w_zugriff && !bus.SpeicherBereit) begin
        r_zaehler <= r_zaehler + 1'b1;
      end
      if (w_timeout) begin
        r_fehler <= 1'b1;
      end
    end
  end

  assign bus.Fehler = r_fehler;
`else
  assign w_timeout  = 1'b0;
  assign bus.Fehler = 1'b0;
`endif

  always_comb begin
    w_naechster = r_zustand;
    case (r_zustand)
      LEER: begin
        if (bus.SchreibeDaten) begin
          w_naechster = SCHREIBEN;
        end else if (bus.LeseDaten) begin
          w_naechster = LESEN;
        end else if (bus.LeseInstruktion) begin
          w_naechster = INSTR;
        end
      end
      INSTR, LESEN, SCHREIBEN: begin
        if (w_beendet) begin
          w_naechster = FERTIG;
        end
      end
      FERTIG:  w_naechster = LEER;
      default: w_naechster = LEER;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_zustand          <= LEER;
      r_adresse          <= '0;
      r_schreibDaten     <= '0;
      r_instruktion      <= '0;
      r_datenRein        <= '0;
      r_lesen            <= 1'b0;
      r_schreiben        <= 1'b0;
      r_instrGeladen     <= 1'b0;
      r_datenGeladen     <= 1'b0;
      r_datenGespeichert <= 1'b0;
    end else begin
      r_zustand          <= w_naechster;
      // Strobes and done pulses are decoded from the upcoming state so they
      // leave a flop exactly aligned with the state they belong to.
      r_lesen            <= (w_naechster == INSTR) || (w_naechster == LESEN);
      r_schreiben        <= (w_naechster == SCHREIBEN);
      r_instrGeladen     <= (r_zustand == INSTR)     && w_beendet;
      r_datenGeladen     <= (r_zustand == LESEN)     && w_beendet;
      r_datenGespeichert <= (r_zustand == SCHREIBEN) && w_beendet;

      if (r_zustand == LEER) begin
        if (bus.SchreibeDaten) begin
          r_adresse      <= bus.DatenAdresse;
          r_schreibDaten <= bus.DatenRaus;
        end else if (bus.LeseDaten) begin
          r_adresse      <= bus.DatenAdresse;
        end else if (bus.LeseInstruktion) begin
          r_adresse      <= bus.InstruktionAdresse;
        end
      end

      if ((r_zustand == INSTR) && w_beendet) begin
        r_instruktion <= bus.SpeicherBereit ? bus.SpeicherLeseDaten : FEHLER_WORT;
      end
      if ((r_zustand == LESEN) && w_beendet) begin
        r_datenRein   <= bus.SpeicherBereit ? bus.SpeicherLeseDaten : FEHLER_WORT;
      end
    end
  end

  assign bus.Instruktion          = r_instruktion;
  assign bus.InstruktionGeladen   = r_instrGeladen;
  assign bus.DatenRein            = r_datenRein;
  assign bus.DatenGeladen         = r_datenGeladen;
  assign bus.DatenGespeichert     = r_datenGespeichert;
  assign bus.SpeicherAdresse      = r_adresse;
  assign bus.SpeicherSchreibDaten = r_schreibDaten;
  assign bus.SpeicherLesen        = r_lesen;
  assign bus.SpeicherSchreiben    = r_schreiben;

endmodule
`default_nettype wire

// File: tb/tb_speicher_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_speicher_arbiter
// Brief    : Self-checking bench: memory responder, bus/done monitors and a
//            transaction-level reference (priority order + reference memory).
// Revision : 1.0 - initial release
// ============================================================================
module tb_speicher_arbiter;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  speicher_arbiter_if bus();

  speicher_arbiter #(
    .TIMEOUT_ZYKLEN(4),
    .FEHLER_WORT   (32'hFFFF_FFFF)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // kind: 0 fetch / generic read, 1 load, 2 store (write)
  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; int len; } busEv_t;
  typedef struct { int kind; logic [31:0] data; } doneEv_t;

  busEv_t  busQ[$];
  doneEv_t doneQ[$];
  busEv_t  cur;
  bit      prevStrobe = 1'b0;
  int      bothHigh = 0, unstable = 0, multiPulse = 0;

  logic [31:0] memArr [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  logic        bereit = 1'b0, forceBereit = 1'b0, respEnable = 1'b1;
  int          respCnt = 0, respTarget = 0, fixedDelay = 0;
  logic [31:0] leseDaten = 32'h0;

  assign bus.SpeicherBereit    = bereit | forceBereit;
  assign bus.SpeicherLeseDaten = leseDaten;

  function automatic logic [31:0] hashWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return hashWord(a);
  endfunction

  // Memory: acknowledges after a per-access delay, one-cycle Bereit.
  always @(negedge Clock) begin
    if (bereit) begin
      bereit    = 1'b0;
      respCnt   = 0;
      leseDaten = $urandom;
    end else if ((bus.SpeicherLesen || bus.SpeicherSchreiben) && respEnable) begin
      if (respCnt == 0) respTarget = (fixedDelay != 0) ? fixedDelay : int'($urandom_range(1, 4));
      respCnt++;
      if (respCnt >= respTarget) begin
        bereit = 1'b1;
        if (bus.SpeicherSchreiben) memArr[bus.SpeicherAdresse] = bus.SpeicherSchreibDaten;
        else leseDaten = memArr.exists(bus.SpeicherAdresse) ? memArr[bus.SpeicherAdresse]
                                                            : hashWord(bus.SpeicherAdresse);
      end
    end else if (!(bus.SpeicherLesen || bus.SpeicherSchreiben)) begin
      respCnt = 0;
    end
  end

  // Monitor: records every memory access and every done pulse.
  always @(negedge Clock) begin
    bit s;
    int p;
    s = bus.SpeicherLesen | bus.SpeicherSchreiben;
    if (bus.SpeicherLesen && bus.SpeicherSchreiben) bothHigh++;
    if (s) begin
      if (!prevStrobe) begin
        cur.kind = bus.SpeicherSchreiben ? 2 : 0;
        cur.addr = bus.SpeicherAdresse;
        cur.data = bus.SpeicherSchreibDaten;
        cur.len  = 0;
      end else if (bus.SpeicherAdresse !== cur.addr ||
                   (bus.SpeicherSchreiben && bus.SpeicherSchreibDaten !== cur.data)) begin
        unstable++;
      end
      cur.len++;
    end else if (prevStrobe) begin
      busQ.push_back(cur);
    end
    prevStrobe = s;
    p = int'(bus.InstruktionGeladen) + int'(bus.DatenGeladen) + int'(bus.DatenGespeichert);
    if (p > 1) multiPulse++;
    if (bus.InstruktionGeladen) doneQ.push_back('{0, bus.Instruktion});
    if (bus.DatenGeladen)       doneQ.push_back('{1, bus.DatenRein});
    if (bus.DatenGespeichert)   doneQ.push_back('{2, 32'h0});
  end

  task automatic clearLogs();
    busQ.delete();
    doneQ.delete();
  endtask

  task automatic idleInputs();
    bus.LeseInstruktion = 1'b0;
    bus.LeseDaten       = 1'b0;
    bus.SchreibeDaten   = 1'b0;
  endtask

  // Holds the requested levels, dropping each one at its own done pulse.
  task automatic runBatch(input bit doS, input bit doL, input bit doI,
                          input logic [31:0] aS, input logic [31:0] dS,
                          input logic [31:0] aL, input logic [31:0] aI,
                          output bit timedOut);
    int base, need, cyc;
    base = doneQ.size();
    need = int'(doS) + int'(doL) + int'(doI);
    cyc  = 0;
    bus.DatenAdresse       = doS ? aS : aL;
    bus.DatenRaus          = dS;
    bus.InstruktionAdresse = aI;
    bus.SchreibeDaten      = doS;
    bus.LeseDaten          = doL;
    bus.LeseInstruktion    = doI;
    while ((doneQ.size() - base) < need && cyc < 200) begin
      @(negedge Clock); #1;
      cyc++;
      for (int i = base; i < doneQ.size(); i++) begin
        case (doneQ[i].kind)
          0: bus.LeseInstruktion = 1'b0;
          1: bus.LeseDaten       = 1'b0;
          default: begin
            bus.SchreibeDaten = 1'b0;
            bus.DatenAdresse  = aL;
            bus.DatenRaus     = $urandom;
          end
        endcase
      end
    end
    timedOut = ((doneQ.size() - base) < need);
    idleInputs();
    repeat (2) @(negedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idleInputs();
    repeat (2) @(negedge Clock);
    #1;
    nCompared++;
    if ({bus.SpeicherLesen, bus.SpeicherSchreiben, bus.InstruktionGeladen,
         bus.DatenGeladen, bus.DatenGespeichert, bus.Fehler} !== 6'b0) begin
      nMismatched++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bus.SpeicherLesen, bus.SpeicherSchreiben,
               bus.InstruktionGeladen, bus.DatenGeladen, bus.DatenGespeichert, bus.Fehler});
    end
    nCompared++;
    if (bus.Instruktion !== 32'h0 || bus.DatenRein !== 32'h0) begin
      nMismatched++;
      $display("FAIL reset_data: got %h/%h expected 0/0", bus.Instruktion, bus.DatenRein);
    end
    nCompared++;
    if (bus.SpeicherAdresse !== 32'h0 || bus.SpeicherSchreibDaten !== 32'h0) begin
      nMismatched++;
      $display("FAIL reset_bus: got %h/%h expected 0/0", bus.SpeicherAdresse, bus.SpeicherSchreibDaten);
    end
    Reset = 1'b0;
    @(negedge Clock); #1;
  endtask

  task automatic test_fetch();
    bit to;
    clearLogs();
    memArr[32'h40] = 32'h1234_5678;
    fixedDelay = 3;
    runBatch(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0000_0040, to);
    bus.InstruktionAdresse = 32'hDEAD_0000;
    repeat (3) @(negedge Clock);
    #1;
    nCompared++;
    if (to || doneQ.size() != 1 || busQ.size() != 1) begin
      nMismatched++;
      $display("FAIL fetch_count: got done=%0d acc=%0d expected 1/1", doneQ.size(), busQ.size());
    end else begin
      nCompared++;
      if (doneQ[0].kind != 0 || doneQ[0].data !== 32'h1234_5678) begin
        nMismatched++;
        $display("FAIL fetch_done: got kind %0d data %h expected 0 12345678", doneQ[0].kind, doneQ[0].data);
      end
      nCompared++;
      if (busQ[0].kind != 0 || busQ[0].addr !== 32'h40 || busQ[0].len != 3) begin
        nMismatched++;
        $display("FAIL fetch_bus: got kind %0d addr %h len %0d expected 0 00000040 3",
                 busQ[0].kind, busQ[0].addr, busQ[0].len);
      end
    end
    nCompared++;
    if (bus.Instruktion !== 32'h1234_5678) begin
      nMismatched++;
      $display("FAIL fetch_hold: got %h expected 12345678", bus.Instruktion);
    end
    fixedDelay = 0;
  endtask

  task automatic test_priority();
    bit to;
    logic [31:0] aI;
    clearLogs();
    aI = 32'h0000_0080;
    runBatch(1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0000_0100, aI, to);
    nCompared++;
    if (to || doneQ.size() != 2 || busQ.size() != 2) begin
      nMismatched++;
      $display("FAIL prio_count: got done=%0d acc=%0d expected 2/2", doneQ.size(), busQ.size());
    end else begin
      nCompared++;
      if (doneQ[0].kind != 1 || doneQ[0].data !== refRead(32'h100) || busQ[0].addr !== 32'h100) begin
        nMismatched++;
        $display("FAIL prio_first: got kind %0d data %h addr %h expected 1 %h 00000100",
                 doneQ[0].kind, doneQ[0].data, busQ[0].addr, refRead(32'h100));
      end
      nCompared++;
      if (doneQ[1].kind != 0 || doneQ[1].data !== refRead(aI) || busQ[1].addr !== aI) begin
        nMismatched++;
        $display("FAIL prio_second: got kind %0d data %h addr %h expected 0 %h %h",
                 doneQ[1].kind, doneQ[1].data, busQ[1].addr, refRead(aI), aI);
      end
    end
  endtask

  task automatic test_store_stable();
    int cyc;
    clearLogs();
    fixedDelay = 4;
    bus.DatenAdresse  = 32'h200;
    bus.DatenRaus     = 32'hCAFE_F00D;
    bus.SchreibeDaten = 1'b1;
    @(negedge Clock); #1;
    bus.DatenRaus    = 32'h0;
    bus.DatenAdresse = 32'h0;
    cyc = 0;
    while (doneQ.size() == 0 && cyc < 50) begin
      @(negedge Clock); #1;
      cyc++;
    end
    idleInputs();
    refMem[32'h200] = 32'hCAFE_F00D;
    repeat (3) @(negedge Clock);
    #1;
    nCompared++;
    if (doneQ.size() != 1 || busQ.size() != 1) begin
      nMismatched++;
      $display("FAIL store_count: got done=%0d acc=%0d expected 1/1", doneQ.size(), busQ.size());
    end else begin
      nCompared++;
      if (doneQ[0].kind != 2 || busQ[0].kind != 2 || busQ[0].addr !== 32'h200 ||
          busQ[0].data !== 32'hCAFE_F00D || busQ[0].len != 4) begin
        nMismatched++;
        $display("FAIL store_bus: got kind %0d addr %h data %h len %0d expected 2 00000200 cafef00d 4",
                 busQ[0].kind, busQ[0].addr, busQ[0].data, busQ[0].len);
      end
    end
    nCompared++;
    if (unstable != 0) begin
      nMismatched++;
      $display("FAIL store_stable: got %0d bus changes expected 0", unstable);
    end
    fixedDelay = 0;
  endtask

  task automatic test_hold();
    int cyc;
    clearLogs();
    fixedDelay = 1;
    bus.DatenAdresse = 32'h200;
    bus.LeseDaten    = 1'b1;
    @(negedge Clock); #1;
    nCompared++;
    if (bus.SpeicherLesen !== 1'b1) begin
      nMismatched++;
      $display("FAIL latency: got SpeicherLesen=%b expected 1", bus.SpeicherLesen);
    end
    cyc = 0;
    while (doneQ.size() == 0 && cyc < 50) begin
      @(negedge Clock); #1;
      cyc++;
    end
    // request stays high across the edge that leaves the done cycle
    @(negedge Clock); #1;
    idleInputs();
    repeat (4) @(negedge Clock);
    #1;
    nCompared++;
    if (busQ.size() != 1 || doneQ.size() != 1) begin
      nMismatched++;
      $display("FAIL hold_reissue: got acc=%0d done=%0d expected 1/1", busQ.size(), doneQ.size());
    end
    nCompared++;
    if (bus.DatenRein !== 32'hCAFE_F00D) begin
      nMismatched++;
      $display("FAIL hold_data: got %h expected cafef00d", bus.DatenRein);
    end
    fixedDelay = 0;
  endtask

  task automatic test_idle_bereit();
    clearLogs();
    forceBereit = 1'b1;
    repeat (3) @(negedge Clock);
    #1;
    forceBereit = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    nCompared++;
    if (doneQ.size() != 0 || busQ.size() != 0 || bus.DatenRein !== 32'hCAFE_F00D) begin
      nMismatched++;
      $display("FAIL idle_bereit: got done=%0d acc=%0d DatenRein=%h expected 0 0 cafef00d",
               doneQ.size(), busQ.size(), bus.DatenRein);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      bit doS, doL, doI, to;
      logic [31:0] aS, dS, aL, aI;
      int pat, n;
      int expKind[3];
      logic [31:0] expAddr[3], expData[3];
      pat = int'($urandom_range(1, 7));
      doS = pat[2]; doL = pat[1]; doI = pat[0];
      aS = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      aL = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      aI = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      dS = $urandom;
      n  = 0;
      if (doS) begin expKind[n] = 2; expAddr[n] = aS; expData[n] = dS; refMem[aS] = dS; n++; end
      if (doL) begin expKind[n] = 1; expAddr[n] = aL; expData[n] = refRead(aL); n++; end
      if (doI) begin expKind[n] = 0; expAddr[n] = aI; expData[n] = refRead(aI); n++; end
      clearLogs();
      runBatch(doS, doL, doI, aS, dS, aL, aI, to);
      nCompared++;
      if (to || doneQ.size() != n || busQ.size() != n) begin
        nMismatched++;
        $display("FAIL rand_count it%0d: got done=%0d acc=%0d expected %0d", it, doneQ.size(), busQ.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          nCompared++;
          if (doneQ[k].kind != expKind[k] || (expKind[k] != 2 && doneQ[k].data !== expData[k])) begin
            nMismatched++;
            $display("FAIL rand_done it%0d.%0d: got kind %0d data %h expected %0d %h",
                     it, k, doneQ[k].kind, doneQ[k].data, expKind[k], expData[k]);
          end
          nCompared++;
          if (busQ[k].kind != ((expKind[k] == 2) ? 2 : 0) || busQ[k].addr !== expAddr[k] ||
              (expKind[k] == 2 && busQ[k].data !== expData[k])) begin
            nMismatched++;
            $display("FAIL rand_bus it%0d.%0d: got kind %0d addr %h data %h expected %0d %h %h",
                     it, k, busQ[k].kind, busQ[k].addr, busQ[k].data, expKind[k], expAddr[k], expData[k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    clearLogs();
    respEnable = 1'b0;
    bus.InstruktionAdresse = 32'h44;
    bus.LeseInstruktion    = 1'b1;
    cyc = 0;
    while (!bus.SpeicherLesen && cyc < 10) begin
      @(negedge Clock); #1;
      cyc++;
    end
    @(negedge Clock); #1;
    Reset = 1'b1;
    idleInputs();
    @(negedge Clock); #1;
    nCompared++;
    if ({bus.SpeicherLesen, bus.SpeicherSchreiben, bus.InstruktionGeladen,
         bus.DatenGeladen, bus.DatenGespeichert} !== 5'b0) begin
      nMismatched++;
      $display("FAIL midreset_ctrl: got %b expected 00000", {bus.SpeicherLesen, bus.SpeicherSchreiben,
               bus.InstruktionGeladen, bus.DatenGeladen, bus.DatenGespeichert});
    end
    nCompared++;
    if (bus.Instruktion !== 32'h0 || bus.DatenRein !== 32'h0 || bus.SpeicherAdresse !== 32'h0) begin
      nMismatched++;
      $display("FAIL midreset_data: got %h/%h/%h expected 0/0/0",
               bus.Instruktion, bus.DatenRein, bus.SpeicherAdresse);
    end
    Reset = 1'b0;
    respEnable = 1'b1;
    repeat (5) @(negedge Clock);
    #1;
    nCompared++;
    if (doneQ.size() != 0) begin
      nMismatched++;
      $display("FAIL midreset_pulse: got %0d done pulses expected 0", doneQ.size());
    end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    bit to;
    clearLogs();
    respEnable = 1'b0;
    bus.DatenAdresse = 32'h300;
    bus.LeseDaten    = 1'b1;
    cyc = 0;
    while (doneQ.size() == 0 && cyc < 50) begin
      @(negedge Clock); #1;
      cyc++;
    end
    idleInputs();
    respEnable = 1'b1;
    repeat (2) @(negedge Clock);
    #1;
    nCompared++;
    if (doneQ.size() != 1 || busQ.size() != 1) begin
      nMismatched++;
      $display("FAIL timeout_count: got done=%0d acc=%0d expected 1/1", doneQ.size(), busQ.size());
    end else begin
      nCompared++;
      if (doneQ[0].kind != 1 || doneQ[0].data !== 32'hFFFF_FFFF || busQ[0].len != 4) begin
        nMismatched++;
        $display("FAIL timeout_done: got kind %0d data %h len %0d expected 1 ffffffff 4",
                 doneQ[0].kind, doneQ[0].data, busQ[0].len);
      end
    end
    nCompared++;
    if (bus.Fehler !== 1'b1) begin
      nMismatched++;
      $display("FAIL timeout_flag: got %b expected 1", bus.Fehler);
    end
    runBatch(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h1004, to);
    nCompared++;
    if (to || bus.Fehler !== 1'b1 || bus.Instruktion !== refRead(32'h1004)) begin
      nMismatched++;
      $display("FAIL timeout_sticky: got Fehler=%b Instruktion=%h expected 1 %h",
               bus.Fehler, bus.Instruktion, refRead(32'h1004));
    end
  endtask
`else
  task automatic test_no_timeout();
    nCompared++;
    if (bus.Fehler !== 1'b0) begin
      nMismatched++;
      $display("FAIL fehler_off: got %b expected 0", bus.Fehler);
    end
  endtask
`endif

  task automatic test_invariants();
    nCompared++;
    if (bothHigh != 0 || multiPulse != 0 || unstable != 0) begin
      nMismatched++;
      $display("FAIL invariants: got both=%0d multi=%0d unstable=%0d expected 0 0 0",
               bothHigh, multiPulse, unstable);
    end
  endtask

  initial begin
    Reset                  = 1'b1;
    bus.InstruktionAdresse = 32'h0;
    bus.DatenAdresse       = 32'h0;
    bus.DatenRaus          = 32'h0;
    idleInputs();
    test_reset();
    test_fetch();
    test_priority();
    test_store_stable();
    test_hold();
    test_idle_bereit();
    test_random();
    test_reset_mid();
`ifdef TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
